// File: rtl/cfg_frame_loader.sv
// Framed, multi-lane configuration loader on the tile daisy chain.
// Every frame is forwarded downstream one cycle late. The local config
// word is loaded on an ID match or broadcast. A readback frame streams
// the stored word back out on rb_bits.
module cfg_frame_loader #(
    parameter int                    CFG_SIZE = 32,
    parameter int                    LANES    = 1,
    parameter int                    ID_WIDTH = 8,
    parameter logic [ID_WIDTH-1:0]   ID       = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_in_start,
    input  logic [LANES-1:0]    cfg_bit_in,
    input  logic                cfg_bit_in_valid,
    output logic                cfg_out_start,
    output logic [LANES-1:0]    cfg_bit_out,
    output logic                cfg_bit_out_valid,
    output logic [CFG_SIZE-1:0] cfg,
    output logic                cfg_sr_pulse,
    output logic                cfg_busy,
    output logic [LANES-1:0]    rb_bits,
    output logic                rb_valid
);
    localparam int H     = ID_WIDTH + 1;
    localparam int HB    = (H + LANES - 1) / LANES;
    localparam int PB    = (CFG_SIZE + LANES - 1) / LANES;
    localparam int MAXB  = (HB > PB) ? HB : PB;
    localparam int CNT_W = $clog2(MAXB + 1);
    localparam int HW    = HB * LANES;
    localparam int PW    = PB * LANES;
    localparam logic [ID_WIDTH-1:0] BCAST = '1;

    typedef enum logic [2:0] {IDLE, HDR, LOAD, SKIP, READ} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [HW-1:0]       hdr_reg, hdr_next, hdr_merged;
    logic [PW-1:0]       shadow_reg, shadow_next, shadow_merged;
    logic [CFG_SIZE-1:0] cfg_reg, cfg_next;
    logic                pulse_reg, pulse_next;
    logic                busy_reg;
    logic                rb_valid_reg, rb_valid_next;
    logic [LANES-1:0]    rb_bits_reg, rb_bits_next;
    logic                fwd_start_reg, fwd_valid_reg;
    logic [LANES-1:0]    fwd_bits_reg;
    logic [PW-1:0]       cfg_pad;
    logic                beat_ok;
    logic [ID_WIDTH-1:0] hdr_id;
    logic                hdr_rb;

    // A beat arriving together with a start pulse is forwarded but never consumed.
    assign beat_ok = cfg_bit_in_valid & ~cfg_in_start;
    assign cfg_pad = PW'(cfg_reg);
    assign hdr_id  = hdr_merged[ID_WIDTH-1:0];
    assign hdr_rb  = hdr_merged[ID_WIDTH];

    // Header/shadow images with the current beat dropped into its slot, so the
    // decode and the commit can act on the final beat in the same cycle.
    generate
        for (genvar gi = 0; gi < HB; gi++) begin : g_hdr
            assign hdr_merged[gi*LANES +: LANES] =
                (cnt_reg == CNT_W'(gi)) ? cfg_bit_in : hdr_reg[gi*LANES +: LANES];
        end
        for (genvar gi = 0; gi < PB; gi++) begin : g_shadow
            assign shadow_merged[gi*LANES +: LANES] =
                (cnt_reg == CNT_W'(gi)) ? cfg_bit_in : shadow_reg[gi*LANES +: LANES];
        end
    endgenerate

    // Unconditional one-cycle forwarding of the daisy chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_start_reg <= 1'b0;
            fwd_bits_reg  <= '0;
            fwd_valid_reg <= 1'b0;
        end else begin
            fwd_start_reg <= cfg_in_start;
            fwd_bits_reg  <= cfg_bit_in;
            fwd_valid_reg <= cfg_bit_in_valid;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            hdr_reg      <= '0;
            shadow_reg   <= '0;
            cfg_reg      <= '0;
            pulse_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            rb_valid_reg <= 1'b0;
            rb_bits_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            hdr_reg      <= hdr_next;
            shadow_reg   <= shadow_next;
            cfg_reg      <= cfg_next;
            pulse_reg    <= pulse_next;
            busy_reg     <= (state_next != IDLE);
            rb_valid_reg <= rb_valid_next;
            rb_bits_reg  <= rb_bits_next;
        end
    end

    // Next-state and datapath decisions; a start pulse always wins and restarts the header.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        hdr_next      = hdr_reg;
        shadow_next   = shadow_reg;
        cfg_next      = cfg_reg;
        pulse_next    = 1'b0;
        rb_valid_next = 1'b0;
        rb_bits_next  = '0;
        if (cfg_in_start) begin
            state_next = HDR;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                HDR: begin
                    if (beat_ok) begin
                        hdr_next = hdr_merged;
                        if (cnt_reg == CNT_W'(HB - 1)) begin
                            cnt_next = '0;
                            if (!hdr_rb && (hdr_id == ID || hdr_id == BCAST)) begin
                                state_next = LOAD;
                            end else if (hdr_rb && hdr_id == ID) begin
                                state_next    = READ;
                                rb_valid_next = 1'b1;
                                rb_bits_next  = cfg_pad[LANES-1:0];
                            end else begin
                                state_next = SKIP;
                            end
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                LOAD: begin
                    if (beat_ok) begin
                        shadow_next = shadow_merged;
                        if (cnt_reg == CNT_W'(PB - 1)) begin
                            cfg_next   = shadow_merged[CFG_SIZE-1:0];
                            pulse_next = 1'b1;
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                SKIP: begin
                    if (beat_ok) begin
                        if (cnt_reg == CNT_W'(PB - 1)) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                READ: begin
                    // cnt_reg is the beat currently on rb_bits; input beats are ignored here.
                    if (cnt_reg == CNT_W'(PB - 1)) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next      = cnt_reg + CNT_W'(1);
                        rb_valid_next = 1'b1;
                        rb_bits_next  = LANES'(cfg_pad >> ((int'(cnt_reg) + 1) * LANES));
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign cfg_out_start     = fwd_start_reg;
    assign cfg_bit_out       = fwd_bits_reg;
    assign cfg_bit_out_valid = fwd_valid_reg;
    assign cfg               = cfg_reg;
    assign cfg_sr_pulse      = pulse_reg;
    assign cfg_busy          = busy_reg;
    assign rb_bits           = rb_bits_reg;
    assign rb_valid          = rb_valid_reg;
endmodule

// File: tb/tb_cfg_frame_loader.sv
// Bench for cfg_frame_loader with CFG_SIZE=10, LANES=4, ID_WIDTH=4, ID=7.
module tb_cfg_frame_loader;
    localparam int HB = 2;
    localparam int PB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] bits = 4'h0;
    logic       valid = 1'b0;
    logic       out_start, out_valid, sr_pulse, busy, rbv;
    logic [3:0] out_bits, rbb;
    logic [9:0] cfg;

    int checks = 0;
    int errors = 0;

    cfg_frame_loader #(.CFG_SIZE(10), .LANES(4), .ID_WIDTH(4), .ID(4'd7)) dut (
        .clk(clk), .rst(rst),
        .cfg_in_start(start), .cfg_bit_in(bits), .cfg_bit_in_valid(valid),
        .cfg_out_start(out_start), .cfg_bit_out(out_bits), .cfg_bit_out_valid(out_valid),
        .cfg(cfg), .cfg_sr_pulse(sr_pulse), .cfg_busy(busy),
        .rb_bits(rbb), .rb_valid(rbv)
    );

    always #5 clk = ~clk;

    // ---------------- frame-level reference model ----------------
    // Tracks a frame by how many beats it has consumed; the header value
    // and payload are rebuilt arithmetically from the beats.
    int   active = 0, reading = 0, nb = 0, rb_pos = 0, kind = 0; // kind: 1 load, 2 read, 3 skip
    int   hdr = 0, pay = 0, m_cfg = 0;
    logic e_fs = 0, e_fv = 0, e_pulse = 0, e_busy = 0, e_rbv = 0;
    logic [3:0] e_fb = 0, e_rbb = 0;
    logic model_live = 0;

    always @(posedge clk) begin
        e_fs = start; e_fb = bits; e_fv = valid;
        e_pulse = 0; e_rbv = 0; e_rbb = 0;
        if (rst) begin
            active = 0; reading = 0; m_cfg = 0;
            e_fs = 0; e_fb = 0; e_fv = 0;
        end else if (start) begin
            active = 1; reading = 0; nb = 0; hdr = 0; pay = 0; kind = 0;
        end else if (active != 0 && reading != 0) begin
            rb_pos++;
            if (rb_pos < PB) begin
                e_rbv = 1; e_rbb = 4'((m_cfg >> (4 * rb_pos)) & 15);
            end else begin
                active = 0; reading = 0;
            end
        end else if (active != 0 && valid) begin
            nb++;
            if (nb <= HB) begin
                hdr = hdr | (int'(bits) << (4 * (nb - 1)));
                if (nb == HB) begin
                    if (((hdr >> 4) & 1) == 0 && ((hdr & 15) == 7 || (hdr & 15) == 15)) kind = 1;
                    else if (((hdr >> 4) & 1) == 1 && (hdr & 15) == 7) begin
                        kind = 2; reading = 1; rb_pos = 0;
                        e_rbv = 1; e_rbb = 4'(m_cfg & 15);
                    end else kind = 3;
                end
            end else begin
                pay = pay | (int'(bits) << (4 * (nb - HB - 1)));
                if (nb == HB + PB) begin
                    if (kind == 1) begin
                        m_cfg = pay & 10'h3FF; e_pulse = 1;
                    end
                    active = 0;
                end
            end
        end
        e_busy = (active != 0);
        model_live = 1;
    end

    // ---------------- per-cycle compare ----------------
    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            cmp("fwd_start", int'(out_start), int'(e_fs));
            cmp("fwd_bits",  int'(out_bits),  int'(e_fb));
            cmp("fwd_valid", int'(out_valid), int'(e_fv));
            cmp("cfg",       int'(cfg),       m_cfg);
            cmp("sr_pulse",  int'(sr_pulse),  int'(e_pulse));
            cmp("busy",      int'(busy),      int'(e_busy));
            cmp("rb_valid",  int'(rbv),       int'(e_rbv));
            if (e_rbv) cmp("rb_bits", int'(rbb), int'(e_rbb));
        end
    end

    // Observed pulses and readback beats, compared against literals below.
    int pulses = 0;
    logic [3:0] rbq[$];
    always @(negedge clk) begin
        if (model_live) begin
            if (sr_pulse) pulses++;
            if (rbv) rbq.push_back(rbb);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic s, input logic v, input logic [3:0] b);
        @(posedge clk); #1;
        start = s; valid = v; bits = b;
    endtask
    task automatic sof();                   cyc(1'b1, 1'b0, 4'h0); endtask
    task automatic beat(input logic [3:0] b); cyc(1'b0, 1'b1, b);   endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0);
    endtask
    task automatic lit(input string name, input int act, input int exp);
        @(negedge clk);
        cmp(name, act, exp);
        $display("txn %s cfg=%03h pulses=%0d", name, cfg, pulses);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        lit("reset_cfg", int'(cfg), 0);
        cmp("reset_busy", int'(busy), 0);

        // 1: directed load
        sof(); beat(4'h7); beat(4'h0); beat(4'h5); beat(4'hA); beat(4'h2); idle(3);
        lit("load_cfg", int'(cfg), 10'h2A5);
        cmp("model_load_cfg", m_cfg, 10'h2A5);
        cmp("load_pulses", pulses, 1);

        // 2: ID mismatch skipped
        sof(); beat(4'h3); beat(4'h0); beat(4'hF); beat(4'hF); beat(4'hF); idle(3);
        lit("skip_cfg", int'(cfg), 10'h2A5);
        cmp("skip_pulses", pulses, 1);

        // 3: broadcast load, then readback to BCAST is skipped
        sof(); beat(4'hF); beat(4'h0); beat(4'h1); beat(4'h0); beat(4'h0); idle(3);
        lit("bcast_cfg", int'(cfg), 10'h001);
        cmp("bcast_pulses", pulses, 2);
        sof(); beat(4'hF); beat(4'h1); idle(5);
        lit("bcast_rb_none", rbq.size(), 0);

        // 5a: load with two-cycle bubbles between beats
        sof(); beat(4'h7); idle(2); beat(4'h0); idle(2); beat(4'h5); idle(2);
        beat(4'hA); idle(2); beat(4'h2); idle(3);
        lit("bubble_cfg", int'(cfg), 10'h2A5);
        cmp("bubble_pulses", pulses, 3);

        // 4: readback
        sof(); beat(4'h7); beat(4'h1); idle(5);
        lit("rb_count", rbq.size(), 3);
        if (rbq.size() == 3) begin
            cmp("rb_beat0", int'(rbq[0]), 4'h5);
            cmp("rb_beat1", int'(rbq[1]), 4'hA);
            cmp("rb_beat2", int'(rbq[2]), 4'h2);
        end
        cmp("rb_cfg", int'(cfg), 10'h2A5);

        // readback aborted by a new start after its first beat, then a skipped frame
        rbq.delete();
        sof(); beat(4'h7); beat(4'h1); idle(1);
        sof(); beat(4'h3); beat(4'h0); beat(4'hF); beat(4'hF); beat(4'hF); idle(3);
        lit("rb_abort_count", rbq.size(), 2);

        // 5b: abort after payload beat 2; start with valid is not consumed
        sof(); beat(4'h7); beat(4'h0); beat(4'h5); beat(4'hA);
        cyc(1'b1, 1'b1, 4'h9);
        beat(4'h7); beat(4'h0); beat(4'h1); beat(4'h0); beat(4'h0); idle(3);
        lit("abort_cfg", int'(cfg), 10'h001);
        cmp("abort_pulses", pulses, 4);

        // 6: reset mid-LOAD, then a normal load
        sof(); beat(4'h7); beat(4'h0); beat(4'h5); beat(4'hA);
        @(posedge clk); #1 rst = 1'b1; start = 1'b0; valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        lit("rst_cfg", int'(cfg), 0);
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_pulses", pulses, 4);
        sof(); beat(4'h7); beat(4'h0); beat(4'h5); beat(4'hA); beat(4'h2); idle(3);
        lit("post_rst_cfg", int'(cfg), 10'h2A5);
        cmp("post_rst_pulses", pulses, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
